// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter: sequences a bank of 8:1 mux cells, up to 7 bit positions per cycle.
// Optional rotate-right on op=11 when SHIFT_ROTATE_EN is defined; otherwise op=11 is a logical right shift.

module mux81 (
    input  logic [7:0] d,
    input  logic [2:0] sel,
    output logic       y
);
    assign y = d[sel];
endmodule

// state | meaning
// IDLE  | waiting for start, dout holds last result
// SHIFT | one mux step per cycle until rem reaches zero
module shift_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] dout,
    output logic             done,
    output logic             busy
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data, data_nxt;
    logic [4:0]       rem, rem_nxt, rem_left;
    logic [1:0]       opl, opl_nxt;
    logic             sign, sign_nxt;
    logic [WIDTH-1:0] dout_nxt;
    logic             done_nxt;
    logic [2:0]       sel;
    logic [WIDTH-1:0] mux_out;

    assign sel      = (rem > 5'd7) ? 3'd7 : rem[2:0];
    assign rem_left = rem - {2'b00, sel};

    // Mux input j of cell i is the source bit for a shift by j positions.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [7:0] d;
        for (genvar j = 0; j < 8; j++) begin : g_in
            logic sll_b, srl_b, sra_b;
            if (i >= j) begin : g_sll
                assign sll_b = data[i-j];
            end else begin : g_sll_fill
                assign sll_b = 1'b0;
            end
            if (i + j <= WIDTH - 1) begin : g_sr
                assign srl_b = data[i+j];
                assign sra_b = data[i+j];
            end else begin : g_sr_fill
                assign srl_b = 1'b0;
                assign sra_b = sign;
            end
`ifdef SHIFT_ROTATE_EN
            assign d[j] = (opl == 2'b11) ? data[(i+j) % WIDTH] :
                          (opl == 2'b00) ? sll_b :
                          (opl == 2'b10) ? sra_b : srl_b;
`else
            assign d[j] = (opl == 2'b00) ? sll_b :
                          (opl == 2'b10) ? sra_b : srl_b;
`endif
        end
        mux81 u_mux (.d(d), .sel(sel), .y(mux_out[i]));
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = data;
        rem_nxt   = rem;
        opl_nxt   = opl;
        sign_nxt  = sign;
        dout_nxt  = dout;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    data_nxt  = din;
                    rem_nxt   = shamt;
                    opl_nxt   = op;
                    sign_nxt  = din[WIDTH-1];
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                data_nxt = mux_out;
                rem_nxt  = rem_left;
                if (rem_left == 5'd0) begin
                    dout_nxt  = mux_out;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            data  <= '0;
            rem   <= '0;
            opl   <= '0;
            sign  <= 1'b0;
            dout  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            data  <= data_nxt;
            rem   <= rem_nxt;
            opl   <= opl_nxt;
            sign  <= sign_nxt;
            dout  <= dout_nxt;
            done  <= done_nxt;
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: latency, results, back-to-back, reset abort, op=11 behaviour.
`timescale 1ns/1ps
module tb_shift_sequencer;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [1:0]  op;
    logic [31:0] din, dout;
    logic [4:0]  shamt;
    logic        done, busy;
    int          compared = 0;
    int          mismatched = 0;

    shift_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .din(din),
        .shamt(shamt), .dout(dout), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                         input int exp_n, input logic [31:0] exp_dout, input string tag);
        int n;
        op = o; din = d; shamt = s; start = 1'b1;
        tick();
        start = 1'b0; op = ~o; din = 32'hDEAD_BEEF; shamt = 5'd31;
        check({tag, "_busy_t0"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (!done && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, exp_n);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, "_dout"}, dout, exp_dout);
        tick();
        check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        check({tag, "_dout_hold"}, dout, exp_dout);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; din = '0; shamt = '0;
        tick(); tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("idle_dout", dout, 32'd0);
            check("idle_done", {31'd0, done}, 32'd0);
            check("idle_busy", {31'd0, busy}, 32'd0);
        end

        do_op(2'b00, 32'h0000_0001, 5'd31, 5, 32'h8000_0000, "sll31");
        do_op(2'b00, 32'h0000_0001, 5'd0,  1, 32'h0000_0001, "sll0");
        do_op(2'b10, 32'h8000_00F0, 5'd8,  2, 32'hFF80_0000, "sra8");
        do_op(2'b01, 32'h8000_00F0, 5'd8,  2, 32'h0080_0000, "srl8");
        do_op(2'b10, 32'h7000_0000, 5'd4,  1, 32'h0700_0000, "sra_pos4");
        do_op(2'b00, 32'h1234_5678, 5'd16, 3, 32'h5678_0000, "sll16");
        do_op(2'b10, 32'h8000_0000, 5'd31, 5, 32'hFFFF_FFFF, "sra31");
        do_op(2'b01, 32'h8000_0000, 5'd29, 5, 32'h0000_0004, "srl29");
        do_op(2'b00, 32'h0000_0001, 5'd22, 4, 32'h0040_0000, "sll22");
        do_op(2'b00, 32'h0000_0001, 5'd21, 3, 32'h0020_0000, "sll21");

        // back-to-back: second start held high through the first op's done cycle
        op = 2'b01; din = 32'hFFFF_FFFF; shamt = 5'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("b2b_first_done", {31'd0, done}, 32'd1);
        check("b2b_first_dout", dout, 32'h01FF_FFFF);
        op = 2'b00; din = 32'h0000_0001; shamt = 5'd14; start = 1'b1;
        tick();
        check("b2b_accept_busy", {31'd0, busy}, 32'd1);
        check("b2b_accept_done", {31'd0, done}, 32'd0);
        op = 2'b01; din = 32'hAAAA_AAAA; shamt = 5'd3;
        tick();
        start = 1'b0;
        check("b2b_mid_busy", {31'd0, busy}, 32'd1);
        check("b2b_mid_done", {31'd0, done}, 32'd0);
        tick();
        check("b2b_second_done", {31'd0, done}, 32'd1);
        check("b2b_second_dout", dout, 32'h0000_4000);
        tick();
        check("b2b_ignored_busy", {31'd0, busy}, 32'd0);
        check("b2b_ignored_done", {31'd0, done}, 32'd0);

        // reset aborts a 5-cycle op
        op = 2'b00; din = 32'h0000_0001; shamt = 5'd31; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_dout", dout, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("abort_no_done", {31'd0, done}, 32'd0);
        end

        // reset beats a simultaneous start
        rst = 1'b1; start = 1'b1; op = 2'b00; din = 32'h0000_0003; shamt = 5'd1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", {31'd0, busy}, 32'd0);
        tick();
        check("rst_start_done", {31'd0, done}, 32'd0);

        do_op(2'b00, 32'h0000_0003, 5'd1, 1, 32'h0000_0006, "after_abort");

`ifdef SHIFT_ROTATE_EN
        do_op(2'b11, 32'h0000_0001, 5'd1, 1, 32'h8000_0000, "op11");
        do_op(2'b11, 32'h0000_00F1, 5'd12, 2, 32'h0F10_0000, "op11_12");
`else
        do_op(2'b11, 32'h0000_0001, 5'd1, 1, 32'h0000_0000, "op11");
        do_op(2'b11, 32'h0000_00F1, 5'd12, 2, 32'h0000_0000, "op11_12");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
